// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_types
// Shared types for the LC-3b memory subsystem: word and line widths, the
// arbiter state encoding and the owner encoding used by mem_port_arbiter.
// Optional feature macro used by importers: MEM_ARB_RR_EN.
// -----------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic ARB_OWNER_I = 1'b0;
  localparam logic ARB_OWNER_D = 1'b1;

  // A source asserting read and write together is treated as a write.
  function automatic logic arb_op_is_write(input logic rd, input logic wr);
    arb_op_is_write = wr | (rd & wr);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner select between the I-cache and D-cache requests.
// With MEM_ARB_RR_EN defined a tie goes to the side that was not served last;
// otherwise a tie always goes to the D-cache and no history input exists.
// Ports:
//   i_req_i  - I-cache has a request pending
//   i_req_d  - D-cache has a request pending
//   i_last   - (MEM_ARB_RR_EN only) owner of the previous grant
//   o_valid  - at least one request pending
//   o_owner  - winning side (ARB_OWNER_I / ARB_OWNER_D)
// -----------------------------------------------------------------------------
module arb_pick
  import lc3b_types::*;
(
  input  logic i_req_i,
  input  logic i_req_d,
`ifdef MEM_ARB_RR_EN
  input  logic i_last,
`endif
  output logic o_valid,
  output logic o_owner
);

  // Winner selection with tie-break.
  always_comb begin
    o_valid = i_req_i | i_req_d;
    o_owner = ARB_OWNER_I;
    if (i_req_i && i_req_d) begin
`ifdef MEM_ARB_RR_EN
      o_owner = ~i_last;
`else
      o_owner = ARB_OWNER_D;
`endif
    end else if (i_req_d) begin
      o_owner = ARB_OWNER_D;
    end else begin
      o_owner = ARB_OWNER_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single physical-memory port between the I-cache and D-cache.
// The winning request's operation, address and write line are latched in IDLE
// and drive physical memory from registers while BUSY. The pmem response and
// read line are routed back to the owner only; a DONE bubble cycle follows so
// the served cache can drop its request before the next grant.
// Optional feature: MEM_ARB_RR_EN (round-robin tie-break; default is fixed
// D-cache priority on ties).
// Ports:
//   clk, rst_n                               - clock, async active-low reset
//   i_read/i_write/i_address/i_wdata         - I-cache request
//   i_rdata/i_resp                           - I-cache response
//   d_read/d_write/d_address/d_wdata         - D-cache request
//   d_rdata/d_resp                           - D-cache response
//   pmem_read/pmem_write/pmem_address/pmem_wdata - physical-memory command
//   pmem_rdata/pmem_resp                     - physical-memory response
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_read,
  input  logic     i_write,
  input  lc3b_word i_address,
  input  lc3b_line i_wdata,
  output lc3b_line i_rdata,
  output logic     i_resp,
  input  logic     d_read,
  input  logic     d_write,
  input  lc3b_word d_address,
  input  lc3b_line d_wdata,
  output lc3b_line d_rdata,
  output logic     d_resp,
  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp
);

  arb_state_t r_state;
  logic       r_owner;
  logic       r_op_wr;
  lc3b_word   r_addr;
  lc3b_line   r_wdata;
`ifdef MEM_ARB_RR_EN
  logic       r_last;
`endif

  logic w_valid;
  logic w_owner;
  logic w_busy;
  logic w_done_i;
  logic w_done_d;

  arb_pick u_pick (
    .i_req_i (i_read | i_write),
    .i_req_d (d_read | d_write),
`ifdef MEM_ARB_RR_EN
    .i_last  (r_last),
`endif
    .o_valid (w_valid),
    .o_owner (w_owner)
  );

  // Arbiter FSM: latch the winner in IDLE, hold it through BUSY, bubble in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= ARB_OWNER_I;
      r_op_wr <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 128'h0;
`ifdef MEM_ARB_RR_EN
      r_last  <= ARB_OWNER_I;
`endif
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_valid) begin
            r_owner <= w_owner;
            r_state <= ARB_BUSY;
`ifdef MEM_ARB_RR_EN
            r_last  <= w_owner;
`endif
            if (w_owner == ARB_OWNER_D) begin
              r_op_wr <= arb_op_is_write(d_read, d_write);
              r_addr  <= d_address;
              r_wdata <= d_wdata;
            end else begin
              r_op_wr <= arb_op_is_write(i_read, i_write);
              r_addr  <= i_address;
              r_wdata <= i_wdata;
            end
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_BUSY: begin
          // Completion does not depend on the owner still requesting.
          if (pmem_resp) begin
            r_state <= ARB_DONE;
          end else begin
            r_state <= ARB_BUSY;
          end
        end
        ARB_DONE: begin
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Output decode: pmem command only from registers, responses gated to owner.
  always_comb begin
    w_busy       = (r_state == ARB_BUSY);
    w_done_i     = w_busy & pmem_resp & (r_owner == ARB_OWNER_I);
    w_done_d     = w_busy & pmem_resp & (r_owner == ARB_OWNER_D);
    pmem_read    = w_busy & ~r_op_wr;
    pmem_write   = w_busy & r_op_wr;
    pmem_address = w_busy ? r_addr : 16'h0000;
    pmem_wdata   = w_busy ? r_wdata : 128'h0;
    i_resp       = w_done_i;
    d_resp       = w_done_d;
    i_rdata      = (w_busy && (r_owner == ARB_OWNER_I)) ? pmem_rdata : 128'h0;
    d_rdata      = (w_busy && (r_owner == ARB_OWNER_D)) ? pmem_rdata : 128'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Expected transactions are queued when a
// request is driven and popped when physical memory sees the command.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import lc3b_types::*;

  logic     clk;
  logic     rst_n;
  logic     i_read, i_write, d_read, d_write;
  lc3b_word i_address, d_address, pmem_address;
  lc3b_line i_wdata, d_wdata, i_rdata, d_rdata, pmem_wdata, pmem_rdata;
  logic     i_resp, d_resp, pmem_read, pmem_write, pmem_resp;

  typedef struct {
    logic     owner;
    logic     wr;
    lc3b_word addr;
    lc3b_line wdata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;
  int   gap;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_address    (i_address),
    .i_wdata      (i_wdata),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic owner, input logic wr, input lc3b_word addr, input lc3b_line wd);
    exp_t e;
    e.owner = owner; e.wr = wr; e.addr = addr; e.wdata = wd;
    sb.push_back(e);
  endtask

  // Wait for the next pmem command, check it against the queue head, answer it
  // after lat cycles with rd, and return in the DONE cycle. k = idle cycles seen.
  task automatic serve(input lc3b_line rd, input int lat, input bit disturb,
                       input bit drop, output int k);
    exp_t e;
    k = 0;
    #1;
    while (!(pmem_read || pmem_write) && k < 40) begin
      @(negedge clk); #1; k++;
    end
    check("cmd_seen", {127'h0, pmem_read | pmem_write}, 128'h1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 128'h0, 128'h1);
    end else begin
      e = sb.pop_front();
      check("pmem_addr", {112'h0, pmem_address}, {112'h0, e.addr});
      check("pmem_write", {127'h0, pmem_write}, {127'h0, e.wr});
      check("pmem_read", {127'h0, pmem_read}, {127'h0, ~e.wr});
      if (e.wr) check("pmem_wdata", pmem_wdata, e.wdata);
      if (disturb) begin
        i_address = 16'hFFFF; d_address = 16'hEEEE; d_wdata = {8{16'hDEAD}}; i_wdata = {8{16'hBEEF}};
      end
      if (drop) begin
        if (e.owner == ARB_OWNER_D) begin d_read = 1'b0; d_write = 1'b0; end
        else begin i_read = 1'b0; i_write = 1'b0; end
      end
      repeat (lat) @(negedge clk);
      #1;
      check("addr_hold", {112'h0, pmem_address}, {112'h0, e.addr});
      if (e.wr) check("wdata_hold", pmem_wdata, e.wdata);
      check("resp_before", {126'h0, i_resp, d_resp}, 128'h0);
      pmem_rdata = rd;
      pmem_resp  = 1'b1;
      #1;
      check("i_resp", {127'h0, i_resp}, {127'h0, e.owner == ARB_OWNER_I});
      check("d_resp", {127'h0, d_resp}, {127'h0, e.owner == ARB_OWNER_D});
      check("i_rdata", i_rdata, (e.owner == ARB_OWNER_I) ? rd : 128'h0);
      check("d_rdata", d_rdata, (e.owner == ARB_OWNER_D) ? rd : 128'h0);
    end
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = 128'h0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    i_read = 1'b0; i_write = 1'b0; i_address = 16'h0000; i_wdata = 128'h0;
    d_read = 1'b0; d_write = 1'b0; d_address = 16'h0000; d_wdata = 128'h0;
    pmem_rdata = 128'h0; pmem_resp = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd", {126'h0, pmem_read, pmem_write}, 128'h0);
    check("rst_addr", {112'h0, pmem_address}, 128'h0);
    rst_n = 1'b1;

    // Reset mid-BUSY: D read 0x1230, then reset, then a stray pmem_resp
    @(negedge clk);
    d_read = 1'b1; d_address = 16'h1230;
    @(negedge clk); #1;
    check("rb_busy_read", {127'h0, pmem_read}, 128'h1);
    rst_n = 1'b0;
    #1;
    check("rb_cmd0", {126'h0, pmem_read, pmem_write}, 128'h0);
    check("rb_addr0", {112'h0, pmem_address}, 128'h0);
    check("rb_wdata0", pmem_wdata, 128'h0);
    check("rb_resp0", {126'h0, i_resp, d_resp}, 128'h0);
    check("rb_rdata0", i_rdata | d_rdata, 128'h0);
    d_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pmem_rdata = {8{16'h5A5A}}; pmem_resp = 1'b1;
    #1;
    check("stray_resp", {126'h0, i_resp, d_resp}, 128'h0);
    check("stray_rdata", i_rdata | d_rdata, 128'h0);
    @(negedge clk);
    pmem_resp = 1'b0; pmem_rdata = 128'h0;
    #1;
    check("stray_idle", {126'h0, pmem_read, pmem_write}, 128'h0);

    // I read 0x0040 alone, answered after 5 cycles
    @(negedge clk);
    i_read = 1'b1; i_address = 16'h0040;
    push(ARB_OWNER_I, 1'b0, 16'h0040, 128'h0);
    serve({8{16'hA5A5}}, 5, 1'b0, 1'b0, gap);
    check("i_read_latency", gap, 1);
    i_read = 1'b0;

    // D write 0x8000 with inputs scrambled during BUSY
    @(negedge clk);
    d_write = 1'b1; d_address = 16'h8000; d_wdata = 128'h1;
    push(ARB_OWNER_D, 1'b1, 16'h8000, 128'h1);
    serve(128'h0, 3, 1'b1, 1'b0, gap);
    d_write = 1'b0;

    // D read+write together: write wins
    @(negedge clk);
    d_read = 1'b1; d_write = 1'b1; d_address = 16'h2000; d_wdata = {8{16'h1234}};
    push(ARB_OWNER_D, 1'b1, 16'h2000, {8{16'h1234}});
    serve(128'h0, 2, 1'b0, 1'b0, gap);
    d_read = 1'b0; d_write = 1'b0;

    // I write whose request drops mid-BUSY still completes
    @(negedge clk);
    i_write = 1'b1; i_address = 16'h0100; i_wdata = {8{16'hC0DE}};
    push(ARB_OWNER_I, 1'b1, 16'h0100, {8{16'hC0DE}});
    serve({8{16'h0F0F}}, 2, 1'b0, 1'b1, gap);

    // Simultaneous I and D requests, both held
    repeat (2) @(negedge clk);
    i_read = 1'b1; i_address = 16'h0300;
    d_read = 1'b1; d_address = 16'h0700;
`ifdef MEM_ARB_RR_EN
    push(ARB_OWNER_D, 1'b0, 16'h0700, 128'h0);
    push(ARB_OWNER_I, 1'b0, 16'h0300, 128'h0);
    push(ARB_OWNER_D, 1'b0, 16'h0700, 128'h0);
`else
    push(ARB_OWNER_D, 1'b0, 16'h0700, 128'h0);
    push(ARB_OWNER_D, 1'b0, 16'h0700, 128'h0);
    push(ARB_OWNER_D, 1'b0, 16'h0700, 128'h0);
`endif
    serve({4{32'h11111111}}, 2, 1'b0, 1'b0, gap);
    check("tie_first_latency", gap, 1);
    serve({4{32'h22222222}}, 1, 1'b0, 1'b0, gap);
    check("tie_gap2", gap, 2);
    serve({4{32'h33333333}}, 4, 1'b0, 1'b0, gap);
    check("tie_gap3", gap, 2);
    d_read = 1'b0;
    push(ARB_OWNER_I, 1'b0, 16'h0300, 128'h0);
    serve({4{32'h44444444}}, 1, 1'b0, 1'b0, gap);
    check("tie_gap4", gap, 2);
    i_read = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("final_idle", {126'h0, pmem_read, pmem_write}, 128'h0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
